// File: rtl/pll_seq_pkg.sv
// Shared constants for the PLL reset/lock sequencer: state encoding, default timing
// parameters and the counter-width helper used to size the sequencer's counters.
package pll_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_PLL_RST   = 3'd0;
    localparam state_t ST_WAIT_LOCK = 3'd1;
    localparam state_t ST_STABLE    = 3'd2;
    localparam state_t ST_RUN       = 3'd3;
    localparam state_t ST_FAULT     = 3'd4;

    // 50 MHz reference: 1 ms lock budget, ~20 us stability window.
    localparam int unsigned DEF_RST_PULSE_CYC    = 16;
    localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int unsigned DEF_MAX_RETRIES      = 3;
    localparam int unsigned DEF_SYNC_STAGES      = 2;

    localparam logic [7:0] LOSS_CNT_SAT = 8'd255;

    // Counters compare for equality against their limit, so they only need to hold it.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; no reset so the chain
// stays a plain metastability filter.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q << 1;
        sync_d[0] = d_i;
    end

    always_ff @(posedge clk_i) begin
        sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_sequencer.sv
// PLL bring-up controller: pulses the PLL reset, qualifies a stable lock, releases the
// downstream synchronous reset, and retries with a timeout before latching a fault.
module pll_rst_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
    parameter int unsigned SYNC_STAGES      = DEF_SYNC_STAGES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned PULSE_W  = cnt_width(RST_PULSE_CYC);
    localparam int unsigned STABLE_W = cnt_width(LOCK_STABLE_CYC);
    localparam int unsigned TMO_W    = cnt_width(LOCK_TIMEOUT_CYC);

    localparam logic [PULSE_W-1:0]  PULSE_DONE  = PULSE_W'(RST_PULSE_CYC);
    localparam logic [STABLE_W-1:0] STABLE_DONE = STABLE_W'(LOCK_STABLE_CYC);
    localparam logic [TMO_W-1:0]    TMO_DONE    = TMO_W'(LOCK_TIMEOUT_CYC);
    localparam logic [1:0]          RETRY_LIMIT = 2'(MAX_RETRIES);

    logic locked_s;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i(refclk),
        .d_i  (pll_locked),
        .q_o  (locked_s)
    );

    state_t              state_q, state_d;
    logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [1:0]          retry_cnt_q, retry_cnt_d;
    logic [7:0]          loss_cnt_q, loss_cnt_d;
    logic                pll_rst_q, pll_rst_d;
    logic                sys_rst_q, sys_rst_d;
    logic                ready_q, ready_d;
    logic                fault_q, fault_d;

    logic [STABLE_W-1:0] stable_nxt;
    logic [TMO_W-1:0]    tmo_nxt;
    logic [1:0]          retry_nxt;
    logic                tmo_hit;
    logic                stable_hit;

    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        stable_cnt_d = stable_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        loss_cnt_d   = loss_cnt_q;

        // The first locked cycle seen from WAIT_LOCK already counts toward the window.
        stable_nxt = (state_q == ST_STABLE) ? stable_cnt_q + 1'b1 : STABLE_W'(1);
        tmo_nxt    = tmo_cnt_q + 1'b1;
        retry_nxt  = retry_cnt_q + 1'b1;
        tmo_hit    = (tmo_nxt == TMO_DONE);
        stable_hit = locked_s && (stable_nxt == STABLE_DONE);

        case (state_q)
            ST_PLL_RST: begin
                if (pulse_cnt_q == PULSE_DONE) begin
                    state_d      = ST_WAIT_LOCK;
                    tmo_cnt_d    = '0;
                    stable_cnt_d = '0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                tmo_cnt_d = tmo_nxt;
                if (tmo_hit) begin
                    retry_cnt_d  = retry_nxt;
                    stable_cnt_d = '0;
                    if (retry_nxt == RETRY_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d     = ST_PLL_RST;
                        pulse_cnt_d = PULSE_W'(1);
                    end
                end else if (stable_hit) begin
                    state_d      = ST_RUN;
                    stable_cnt_d = stable_nxt;
                    retry_cnt_d  = '0;
                end else if (locked_s) begin
                    state_d      = ST_STABLE;
                    stable_cnt_d = stable_nxt;
                end else begin
                    state_d      = ST_WAIT_LOCK;
                    stable_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d     = ST_PLL_RST;
                    pulse_cnt_d = PULSE_W'(1);
                    if (loss_cnt_q != LOSS_CNT_SAT) begin
                        loss_cnt_d = loss_cnt_q + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (retry_req) begin
                    state_d     = ST_PLL_RST;
                    pulse_cnt_d = PULSE_W'(1);
                    retry_cnt_d = '0;
                end
            end
            default: begin
                state_d     = ST_PLL_RST;
                pulse_cnt_d = PULSE_W'(1);
            end
        endcase

        // Outputs follow the next state so they are registered alongside it.
        pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= ST_PLL_RST;
            pulse_cnt_q  <= '0;
            stable_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            retry_cnt_q  <= '0;
            loss_cnt_q   <= '0;
            pll_rst_q    <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_cnt_q  <= pulse_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            loss_cnt_q   <= loss_cnt_d;
            pll_rst_q    <= pll_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_cnt_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Bench for pll_rst_sequencer: a timestamp-based model of the bring-up rules checked
// every cycle, plus directed scenarios pinned with hand-computed cycle expectations.
module tb_pll_rst_sequencer;

    localparam int RST_P = 4;
    localparam int STB_P = 8;
    localparam int TMO_P = 32;
    localparam int MAXR  = 2;
    localparam int SYNC  = 2;

    localparam int P_PULSE = 0;
    localparam int P_ACQ   = 1;
    localparam int P_RUN   = 2;
    localparam int P_FAULT = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    pll_rst_sequencer #(
        .RST_PULSE_CYC   (RST_P),
        .LOCK_STABLE_CYC (STB_P),
        .LOCK_TIMEOUT_CYC(TMO_P),
        .MAX_RETRIES     (MAXR),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .retry_req    (retry_req),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #10 refclk = ~refclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: edge index since reset release, phase, and absolute deadlines.
    int              ecount = -1;
    int              phase = P_PULSE;
    int              leave_at = 0;
    int              deadline = 0;
    int              run_first = -1;
    int              retries = 0;
    int              losses = 0;
    logic [SYNC-1:0] hist = '0;
    bit              model_valid = 0;

    task automatic model_step();
        logic ls;
        ls   = hist[SYNC-1];
        hist = {hist[SYNC-2:0], pll_locked};
        if (rst) begin
            ecount      = -1;
            phase       = P_PULSE;
            leave_at    = RST_P;
            retries     = 0;
            losses      = 0;
            model_valid = 1;
        end else begin
            ecount++;
            case (phase)
                P_PULSE: begin
                    if (ecount == leave_at) begin
                        phase     = P_ACQ;
                        deadline  = ecount + TMO_P;
                        run_first = -1;
                    end
                end
                P_ACQ: begin
                    if (ecount == deadline) begin
                        retries++;
                        phase    = (retries == MAXR) ? P_FAULT : P_PULSE;
                        leave_at = ecount + RST_P;
                    end else if (ls) begin
                        if (run_first < 0) run_first = ecount;
                        if (ecount - run_first + 1 == STB_P) begin
                            phase   = P_RUN;
                            retries = 0;
                        end
                    end else begin
                        run_first = -1;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        phase    = P_PULSE;
                        leave_at = ecount + RST_P;
                        if (losses < 255) losses++;
                    end
                end
                default: begin
                    if (retry_req) begin
                        phase    = P_PULSE;
                        leave_at = ecount + RST_P;
                        retries  = 0;
                    end
                end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge refclk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge refclk);
            if (model_valid) begin
                chk("pll_rst", int'(pll_rst), int'(phase == P_PULSE || phase == P_FAULT));
                chk("sys_rst", int'(sys_rst), int'(phase != P_RUN));
                chk("ready", int'(ready), int'(phase == P_RUN));
                chk("fault", int'(fault), int'(phase == P_FAULT));
                chk("retry_cnt", int'(retry_cnt), retries);
                chk("lock_loss_cnt", int'(lock_loss_cnt), losses);
            end
        end
    end

    task automatic wait_cyc(input int k);
        int g = 0;
        while (ecount < k && g < 2000) begin
            @(negedge refclk);
            g++;
        end
        chk("wait_cyc", ecount, k);
    endtask

    task automatic wait_ready(input logic level, input int budget, input string name);
        int g = 0;
        while (ready !== level && g < budget) begin
            @(negedge refclk);
            g++;
        end
        chk(name, int'(ready), int'(level));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        retry_req  = 1'b0;
        repeat (4) @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean bring-up
        do_reset();
        chk("t1_reset_pll_rst", int'(pll_rst), 1);
        chk("t1_reset_ready", int'(ready), 0);
        wait_cyc(3);
        chk("t1_pll_rst_c3", int'(pll_rst), 1);
        wait_cyc(4);
        chk("t1_pll_rst_c4", int'(pll_rst), 0);
        wait_cyc(10);
        pll_locked = 1'b1;
        wait_cyc(19);
        chk("t1_ready_c19", int'(ready), 0);
        wait_cyc(20);
        chk("t1_ready_c20", int'(ready), 1);
        chk("t1_sys_rst_c20", int'(sys_rst), 0);
        chk("t1_retry_c20", int'(retry_cnt), 0);

        // One-cycle lock glitch during the stability window
        do_reset();
        wait_cyc(10);
        pll_locked = 1'b1;
        wait_cyc(15);
        pll_locked = 1'b0;
        wait_cyc(16);
        pll_locked = 1'b1;
        wait_cyc(20);
        chk("t2_ready_c20", int'(ready), 0);
        wait_cyc(25);
        chk("t2_ready_c25", int'(ready), 0);
        wait_cyc(26);
        chk("t2_ready_c26", int'(ready), 1);
        chk("t2_fault_c26", int'(fault), 0);

        // Never locks: two timeouts end in FAULT
        do_reset();
        wait_cyc(35);
        chk("t3_retry_c35", int'(retry_cnt), 0);
        chk("t3_pll_rst_c35", int'(pll_rst), 0);
        wait_cyc(36);
        chk("t3_retry_c36", int'(retry_cnt), 1);
        chk("t3_pll_rst_c36", int'(pll_rst), 1);
        wait_cyc(39);
        chk("t3_pll_rst_c39", int'(pll_rst), 1);
        wait_cyc(40);
        chk("t3_pll_rst_c40", int'(pll_rst), 0);
        wait_cyc(71);
        chk("t3_fault_c71", int'(fault), 0);
        wait_cyc(72);
        chk("t3_fault_c72", int'(fault), 1);
        chk("t3_retry_c72", int'(retry_cnt), 2);
        chk("t3_pll_rst_c72", int'(pll_rst), 1);
        chk("t3_sys_rst_c72", int'(sys_rst), 1);

        // Fault recovery via retry_req
        wait_cyc(75);
        pll_locked = 1'b1;
        wait_cyc(80);
        retry_req = 1'b1;
        wait_cyc(81);
        retry_req = 1'b0;
        chk("t6_fault_c81", int'(fault), 0);
        chk("t6_retry_c81", int'(retry_cnt), 0);
        chk("t6_pll_rst_c81", int'(pll_rst), 1);
        wait_cyc(85);
        chk("t6_pll_rst_c85", int'(pll_rst), 0);
        wait_cyc(92);
        chk("t6_ready_c92", int'(ready), 0);
        wait_cyc(93);
        chk("t6_ready_c93", int'(ready), 1);
        wait_cyc(100);
        retry_req = 1'b1;
        wait_cyc(101);
        retry_req = 1'b0;
        chk("t6_ignored_retry_ready", int'(ready), 1);
        chk("t6_ignored_retry_pll_rst", int'(pll_rst), 0);

        // Lock loss in RUN
        wait_cyc(110);
        pll_locked = 1'b0;
        wait_cyc(112);
        chk("t4_ready_c112", int'(ready), 1);
        wait_cyc(113);
        chk("t4_sys_rst_c113", int'(sys_rst), 1);
        chk("t4_ready_c113", int'(ready), 0);
        chk("t4_pll_rst_c113", int'(pll_rst), 1);
        chk("t4_loss_c113", int'(lock_loss_cnt), 1);
        wait_cyc(114);
        pll_locked = 1'b1;
        wait_cyc(124);
        chk("t4_ready_c124", int'(ready), 0);
        wait_cyc(125);
        chk("t4_ready_c125", int'(ready), 1);
        chk("t4_loss_c125", int'(lock_loss_cnt), 1);

        for (int i = 0; i < 260; i++) begin
            wait_ready(1'b1, 40, "t4_relock");
            pll_locked = 1'b0;
            @(negedge refclk);
            pll_locked = 1'b1;
            wait_ready(1'b0, 10, "t4_drop");
            if (i == 8) chk("t4_loss_10", int'(lock_loss_cnt), 10);
        end
        chk("t4_loss_sat", int'(lock_loss_cnt), 255);

        // Synchronous reset in the middle of the stability window (count 5)
        repeat (9) @(negedge refclk);
        chk("t5_ready_before_rst", int'(ready), 0);
        rst = 1'b1;
        @(negedge refclk);
        chk("t5_pll_rst", int'(pll_rst), 1);
        chk("t5_sys_rst", int'(sys_rst), 1);
        chk("t5_ready", int'(ready), 0);
        chk("t5_retry", int'(retry_cnt), 0);
        chk("t5_loss", int'(lock_loss_cnt), 0);
        rst = 1'b0;
        wait_cyc(3);
        chk("t5_pll_rst_c3", int'(pll_rst), 1);
        wait_cyc(4);
        chk("t5_pll_rst_c4", int'(pll_rst), 0);
        wait_cyc(11);
        chk("t5_ready_c11", int'(ready), 0);
        wait_cyc(12);
        chk("t5_ready_c12", int'(ready), 1);
        wait_cyc(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
